bundler_ctrl: RTL

BUNDLER_CTRL -- requirements
Module: bundler_ctrl

---
 rtl/bundler_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bundler_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bundler_ctrl: sequences hypervector chunks through bundler_bits, collects  |
// | the bundled result and flags a per-chunk response timeout.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module bundler_ctrl #(
  parameter int NUM_HVS  = 5,
  parameter int PAR_BITS = 2,
  parameter int DIM      = 6,
  parameter int TIMEOUT  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_HVS-1:0][DIM-1:0]        hvs,
  input  logic [DIM-1:0]                     ties_hv_1,
  input  logic [DIM-1:0]                     ties_hv_2,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [DIM-1:0]                     result,
  output logic                               bb_en,
  output logic [NUM_HVS-1:0][PAR_BITS-1:0]   bb_bits,
  output logic [PAR_BITS-1:0]                bb_ties_1,
  output logic [PAR_BITS-1:0]                bb_ties_2,
  input  logic                               bb_done,
  input  logic [PAR_BITS-1:0]                bb_out_bits
);

  localparam int NCHUNK = DIM / PAR_BITS;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] C_LAST_K   = KW'(NCHUNK - 1);
  localparam logic [CW-1:0] C_LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [KW-1:0]               r_k;
  logic [CW-1:0]               r_cnt;
  logic [NUM_HVS-1:0][DIM-1:0] r_hvs;
  logic [DIM-1:0]              r_ties_1;
  logic [DIM-1:0]              r_ties_2;
  logic [DIM-1:0]              r_result;
  logic                        r_err;
  logic                        w_chunk_live;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT: begin
        if (bb_done)                  w_next = (r_k == C_LAST_K) ? FIN : ISSUE;
        else if (r_cnt == C_LAST_CNT) w_next = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Chunk outputs are only meaningful while a chunk is in flight; zero otherwise.
  always_comb begin
    w_chunk_live = (r_state == ISSUE) || (r_state == WAIT);
    busy         = (r_state != IDLE);
    done         = (r_state == FIN);
    bb_en        = (r_state == ISSUE);
    bb_bits      = '0;
    bb_ties_1    = '0;
    bb_ties_2    = '0;
    if (w_chunk_live) begin
      for (int i = 0; i < NUM_HVS; i++)
        bb_bits[i] = r_hvs[i][r_k*PAR_BITS +: PAR_BITS];
      bb_ties_1 = r_ties_1[r_k*PAR_BITS +: PAR_BITS];
      bb_ties_2 = r_ties_2[r_k*PAR_BITS +: PAR_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_cnt    <= '0;
      r_hvs    <= '0;
      r_ties_1 <= '0;
      r_ties_2 <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_hvs    <= hvs;
            r_ties_1 <= ties_hv_1;
            r_ties_2 <= ties_hv_2;
            r_result <= '0;
            r_err    <= 1'b0;
            r_k      <= '0;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (bb_done) begin
            r_result[r_k*PAR_BITS +: PAR_BITS] <= bb_out_bits;
            if (r_k != C_LAST_K) r_k <= r_k + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST_CNT) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign err    = r_err;

endmodule
`default_nettype wire
